// File: rtl/ps2_rx_frame.sv
// rtl/ps2_rx_frame.sv - host-side PS/2 device-to-host frame receiver with glitch filter and timeout
// Optional odd-parity checking enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx_frame #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 10000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_c,
   input  logic       ps2_d,
   input  logic       rx_en,
   output logic [7:0] dout,
   output logic       rx_done,
   output logic       rx_idle,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t                  state_q, state_d;
   logic                    c_s1, c_s2, d_s1, d_s2;
   logic [FILTER_LEN-1:0]   c_filt, d_dly;
   logic                    c_f;
   logic                    fall_edge, d_bit;
   logic [2:0]              bitcnt_q;
   logic [7:0]              shreg_q, dout_q;
   logic [TCNT_W-1:0]       tcnt_q;
   logic                    done_q, ferr_q;
   logic                    shift_en, clr_cnt, set_done, set_ferr;
`ifdef PS2_RX_PARITY_CHECK_EN
   logic                    par_q, perr_q, store_par, set_perr;
`endif

   // Data is delayed by the same depth as the clock filter so it lines up with the edge.
   always_ff @(posedge clk) begin
      if (!rst) begin
         c_s1   <= 1'b1;
         c_s2   <= 1'b1;
         d_s1   <= 1'b1;
         d_s2   <= 1'b1;
         c_filt <= '1;
         d_dly  <= '1;
         c_f    <= 1'b1;
      end else begin
         c_s1   <= ps2_c;
         c_s2   <= c_s1;
         d_s1   <= ps2_d;
         d_s2   <= d_s1;
         c_filt <= {c_filt[FILTER_LEN-2:0], c_s2};
         d_dly  <= {d_dly[FILTER_LEN-2:0], d_s2};
         if (&c_filt)
            c_f <= 1'b1;
         else if (~|c_filt)
            c_f <= 1'b0;
      end
   end

   assign fall_edge = c_f & ~|c_filt;
   assign d_bit     = d_dly[FILTER_LEN-1];

   always_comb begin
      state_d  = state_q;
      shift_en = 1'b0;
      clr_cnt  = 1'b0;
      set_done = 1'b0;
      set_ferr = 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      store_par = 1'b0;
      set_perr  = 1'b0;
`endif
      if (!rx_en) begin
         state_d = IDLE;
      end else if (state_q != IDLE && !fall_edge && tcnt_q == TCNT_MAX) begin
         state_d  = IDLE;
         set_ferr = 1'b1;
      end else if (fall_edge) begin
         case (state_q)
            IDLE: begin
               if (!d_bit) begin
                  state_d = DATA;
                  clr_cnt = 1'b1;
               end
            end
            DATA: begin
               shift_en = 1'b1;
               if (bitcnt_q == 3'd7)
                  state_d = PARITY;
            end
            PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
               store_par = 1'b1;
`endif
               state_d = STOP;
            end
            STOP: begin
               // A bad stop bit takes precedence over a parity mismatch.
               state_d = IDLE;
               if (!d_bit)
                  set_ferr = 1'b1;
`ifdef PS2_RX_PARITY_CHECK_EN
               else if (!(^{shreg_q, par_q}))
                  set_perr = 1'b1;
`endif
               else
                  set_done = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= IDLE;
         bitcnt_q <= 3'd0;
         shreg_q  <= 8'h00;
         dout_q   <= 8'h00;
         tcnt_q   <= '0;
         done_q   <= 1'b0;
         ferr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= set_done;
         ferr_q  <= set_ferr;
         if (clr_cnt)
            bitcnt_q <= 3'd0;
         else if (shift_en)
            bitcnt_q <= bitcnt_q + 3'd1;
         if (shift_en)
            shreg_q <= {d_bit, shreg_q[7:1]};
         if (set_done)
            dout_q <= shreg_q;
         if (state_q == IDLE || fall_edge)
            tcnt_q <= '0;
         else
            tcnt_q <= tcnt_q + TCNT_W'(1);
      end
   end

`ifdef PS2_RX_PARITY_CHECK_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         par_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         perr_q <= set_perr;
         if (store_par)
            par_q <= d_bit;
      end
   end
   assign parity_err = perr_q;
`else
   assign parity_err = 1'b0;
`endif

   assign dout      = dout_q;
   assign rx_done   = done_q;
   assign frame_err = ferr_q;
   assign rx_idle   = (state_q == IDLE);

endmodule
